// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the three-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_D    = 2'd1,
    TAG_I    = 2'd2,
    TAG_X    = 2'd3
  } tag_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating refusal counter for the instruction-fetch port; flags when the limit is reached.
import mem_arb_pkg::*;

module starve_counter #(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [3:0] LP_LIMIT = 4'(LIMIT);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_LIMIT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_limit = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for CPU data (D), instruction fetch (I) and auxiliary (X) masters.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  tag_e r_tag;
  tag_e r_rr;
  tag_e w_win;
  logic w_at_limit;
  logic w_inc;
  logic w_clr;
  logic w_rd;

  // Grants are forced low while reset is held, independent of the clock.
  always_comb begin
    w_win = TAG_NONE;
    if (!rst_n)                   w_win = TAG_NONE;
    else if (w_at_limit && i_req) w_win = TAG_I;
    else if (d_req)               w_win = TAG_D;
    else if (i_req && x_req)      w_win = r_rr;
    else if (i_req)               w_win = TAG_I;
    else if (x_req)               w_win = TAG_X;
  end

  assign d_gnt  = (w_win == TAG_D);
  assign i_gnt  = (w_win == TAG_I);
  assign x_gnt  = (w_win == TAG_X);
  assign mem_en = (w_win != TAG_NONE);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_win)
      TAG_D: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      TAG_I: begin
        mem_addr  = i_addr;
      end
      TAG_X: begin
        mem_we    = x_we;
        mem_addr  = x_addr;
        mem_wdata = x_wdata;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  assign w_rd  = i_gnt | (d_gnt & ~d_we) | (x_gnt & ~x_we);
  assign w_inc = i_req & ~i_gnt;
  assign w_clr = ~i_req | i_gnt;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_inc),
    .i_clr      (w_clr),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= TAG_NONE;
      r_rr  <= TAG_I;
    end else begin
      r_tag <= w_rd ? w_win : TAG_NONE;
      if (i_gnt)      r_rr <= TAG_X;
      else if (x_gnt) r_rr <= TAG_I;
    end
  end

  assign d_rvalid = (r_tag == TAG_D);
  assign i_rvalid = (r_tag == TAG_I);
  assign x_rvalid = (r_tag == TAG_X);
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;
  assign x_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a read-return scoreboard and a behavioural RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_req, d_we, i_req, x_req, x_we;
  logic [AW-1:0] d_addr, i_addr, x_addr;
  logic [DW-1:0] d_wdata, x_wdata;
  logic          d_gnt, d_rvalid, i_gnt, i_rvalid, x_gnt, x_rvalid;
  logic [DW-1:0] d_rdata, i_rdata, x_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_init;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: unwritten words read back as 0xFF00 | addr.
  logic [15:0] ram [256];
  logic        written [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) written[k] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]     <= mem_wdata;
        written[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]]
                                            : (16'hFF00 | {8'h00, mem_addr[7:0]});
      end
    end
  end

  typedef struct {
    logic        dr, dw;
    logic [15:0] da, dd;
    logic        ir;
    logic [15:0] ia;
    logic        xr, xw;
    logic [15:0] xa, xd;
    logic [2:0]  exp;   // expected {d_gnt, i_gnt, x_gnt}
  } vec_t;

  typedef struct {
    tag_e        tag;
    logic [15:0] data;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  logic [15:0] sh [256];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(input logic dr, input logic dw, input logic [15:0] da,
                              input logic [15:0] dd, input logic ir, input logic [15:0] ia,
                              input logic xr, input logic xw, input logic [15:0] xa,
                              input logic [15:0] xd, input logic [2:0] exp);
    vec_t v;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ir = ir; v.ia = ia;
    v.xr = xr; v.xw = xw; v.xa = xa; v.xd = xd;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", what, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
    i_req = v.ir; i_addr = v.ia;
    x_req = v.xr; x_we = v.xw; x_addr = v.xa; x_wdata = v.xd;
  endtask

  task automatic check_return(input int id);
    exp_t        r;
    logic [2:0]  ev;
    if (sbq.size() > 0) r = sbq.pop_front();
    else begin
      r.tag  = TAG_NONE;
      r.data = '0;
    end
    ev = (r.tag == TAG_D) ? 3'b100 : (r.tag == TAG_I) ? 3'b010 :
         (r.tag == TAG_X) ? 3'b001 : 3'b000;
    chk(id, "rvalid", {29'd0, d_rvalid, i_rvalid, x_rvalid}, {29'd0, ev});
    case (r.tag)
      TAG_D:   chk(id, "d_rdata", {16'd0, d_rdata}, {16'd0, r.data});
      TAG_I:   chk(id, "i_rdata", {16'd0, i_rdata}, {16'd0, r.data});
      TAG_X:   chk(id, "x_rdata", {16'd0, x_rdata}, {16'd0, r.data});
      default: ;
    endcase
  endtask

  task automatic step(input int id, input vec_t v);
    exp_t        e;
    logic        we;
    logic [15:0] a, wd;
    drive(v);
    @(negedge clk);
    check_return(id);
    chk(id, "gnt", {29'd0, d_gnt, i_gnt, x_gnt}, {29'd0, v.exp});
    chk(id, "mem_en", {31'd0, mem_en}, {31'd0, |v.exp});
    e.tag = TAG_NONE; e.data = '0;
    we = 1'b0; a = '0; wd = '0;
    case (v.exp)
      3'b100:  begin e.tag = TAG_D; we = v.dw; a = v.da; wd = v.dd; end
      3'b010:  begin e.tag = TAG_I; we = 1'b0; a = v.ia; end
      3'b001:  begin e.tag = TAG_X; we = v.xw; a = v.xa; wd = v.xd; end
      default: ;
    endcase
    if (v.exp != 3'b000) begin
      chk(id, "mem_we", {31'd0, mem_we}, {31'd0, we});
      chk(id, "mem_addr", {16'd0, mem_addr}, {16'd0, a});
      if (we) chk(id, "mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
    end
    if (e.tag != TAG_NONE && we) begin
      sh[a[7:0]] = wd;
      e.tag = TAG_NONE;
    end else if (e.tag != TAG_NONE) begin
      e.data = sh[a[7:0]];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) sh[k] = 16'hFF00 | 16'(k);

    // Reset with every request asserted: nothing may reach memory.
    rst_n = 1'b0;
    mem_init = 1'b1;
    drive(mk(1, 1, 16'h0001, 16'h5555, 1, 16'h0002, 1, 1, 16'h0003, 16'h6666, 3'b000));
    @(negedge clk);
    @(negedge clk);
    chk(0, "rst_gnt", {29'd0, d_gnt, i_gnt, x_gnt}, 32'd0);
    chk(0, "rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk(0, "rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk(0, "rst_rvalid", {29'd0, d_rvalid, i_rvalid, x_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_init = 1'b0;

    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000));
    tbl.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b100));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 3'b010));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 3'b001));
    tbl.push_back(mk(1, 1, 16'h0002, 16'h00AA, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b100));
    tbl.push_back(mk(1, 0, 16'h0002, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b100));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0040, 1, 0, 16'h0041, 16'h0000,
                       (k % 2 == 0) ? 3'b010 : 3'b001));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 0, 16'h0050, 16'h0000, 1, 16'h0060, 0, 0, 16'h0000, 16'h0000,
                       (k == 4) ? 3'b010 : 3'b100));
    tbl.push_back(mk(1, 0, 16'h0051, 16'h0000, 0, 16'h0000, 1, 1, 16'h0005, 16'h1234, 3'b100));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0005, 16'h1234, 3'b001));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 3'b001));
    tbl.push_back(mk(1, 0, 16'h0011, 16'h0000, 1, 16'h0061, 1, 0, 16'h0031, 16'h0000, 3'b100));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0061, 1, 0, 16'h0031, 16'h0000, 3'b010));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0061, 1, 0, 16'h0031, 16'h0000, 3'b001));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000));

    foreach (tbl[k]) step(k + 1, tbl[k]);

    // Fetch read in flight when reset hits; pointer has moved to X.
    step(100, mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0070, 0, 0, 16'h0000, 16'h0000, 3'b010));
    rst_n = 1'b0;
    drive(mk(1, 0, 16'h0012, 16'h0000, 1, 16'h0071, 1, 0, 16'h0032, 16'h0000, 3'b000));
    @(negedge clk);
    chk(101, "midrst_gnt", {29'd0, d_gnt, i_gnt, x_gnt}, 32'd0);
    chk(101, "midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk(101, "midrst_rvalid", {29'd0, d_rvalid, i_rvalid, x_rvalid}, 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(102, mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0072, 1, 0, 16'h0033, 16'h0000, 3'b010));
    for (int k = 0; k < 5; k++)
      step(103 + k, mk(1, 0, 16'h0013, 16'h0000, 1, 16'h0073, 0, 0, 16'h0000, 16'h0000,
                       (k == 4) ? 3'b010 : 3'b100));
    step(110, mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
